// File: rtl/turn_executor_if.sv
// rtl/turn_executor_if.sv - turn-command bus between command logic and turn executor
//
// Purpose: bundles the command-side request levels and the executor's
// steering/status outputs so both ends share one typed connection.
// Signals:
//   enable             command -> executor  block enable
//   trigger_turn_left  command -> executor  turn-left request level
//   trigger_turn_right command -> executor  turn-right request level
//   trigger_turn_back  command -> executor  turn-around request level
//   move_forward       command -> executor  forward request
//   is_turning         executor -> command  turn in progress
//   out_turn_left      executor -> motion   steer-left drive
//   out_turn_right     executor -> motion   steer-right drive
//   out_move_forward   executor -> motion   gated forward drive
//   out_state[2:0]     executor -> debug    current state encoding
interface turn_executor_if;
  logic       enable;
  logic       trigger_turn_left;
  logic       trigger_turn_right;
  logic       trigger_turn_back;
  logic       move_forward;
  logic       is_turning;
  logic       out_turn_left;
  logic       out_turn_right;
  logic       out_move_forward;
  logic [2:0] out_state;

  modport master (
    output enable, trigger_turn_left, trigger_turn_right, trigger_turn_back, move_forward,
    input  is_turning, out_turn_left, out_turn_right, out_move_forward, out_state
  );

  modport slave (
    input  enable, trigger_turn_left, trigger_turn_right, trigger_turn_back, move_forward,
    output is_turning, out_turn_left, out_turn_right, out_move_forward, out_state
  );
endinterface

// File: rtl/turn_executor.sv
// rtl/turn_executor.sv - qualifies a turn trigger and runs a timed in-place rotation
//
// Purpose: responder side of the turn-command interface. A single trigger held
// for CONFIRM_TIME cycles starts a rotation (TURN_90_TIME cycles, doubled for a
// back turn), followed by SETTLE_TIME cycles with steering released, then the
// block waits for all triggers to drop before it can accept another turn.
// Ports:
//   clk    500 Hz system tick, rising edge
//   rst_n  asynchronous active-low reset
//   bus    turn_executor_if.slave (triggers/enable/forward in, steering/status out)
module turn_executor #(
  parameter int CONFIRM_TIME = 10,
  parameter int TURN_90_TIME = 450,
  parameter int SETTLE_TIME  = 25,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  turn_executor_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_CONFIRM = 3'b001,
    ST_ROTATE  = 3'b010,
    ST_SETTLE  = 3'b011,
    ST_REARM   = 3'b100
  } state_t;

  typedef enum logic [1:0] {
    DIR_L = 2'd0,
    DIR_R = 2'd1,
    DIR_B = 2'd2
  } dir_t;

  localparam logic [CNT_W-1:0] CONF_LAST   = CNT_W'(CONFIRM_TIME - 1);
  localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_90_TIME - 1);
  localparam logic [CNT_W-1:0] BACK_LAST   = CNT_W'(2 * TURN_90_TIME - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TIME - 1);

  state_t           state;
  dir_t             dir;
  logic [CNT_W-1:0] cnt;

  logic [2:0]       trig_vec;
  logic             trig_single;
  logic             trig_none;
  dir_t             trig_dir;
  logic [CNT_W-1:0] rot_last;

  always_comb begin
    trig_vec    = {bus.trigger_turn_back, bus.trigger_turn_right, bus.trigger_turn_left};
    trig_single = (trig_vec == 3'b001) || (trig_vec == 3'b010) || (trig_vec == 3'b100);
    trig_none   = (trig_vec == 3'b000);
    trig_dir    = DIR_L;
    case (trig_vec)
      3'b010:  trig_dir = DIR_R;
      3'b100:  trig_dir = DIR_B;
      default: trig_dir = DIR_L;
    endcase
    // A back turn is simply a right rotation held twice as long.
    rot_last = (dir == DIR_B) ? BACK_LAST : TURN_LAST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      dir   <= DIR_L;
      cnt   <= '0;
    end else if (!bus.enable) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trig_single) begin
            dir   <= trig_dir;
            cnt   <= '0;
            state <= ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          // Any change of the request while qualifying cancels the turn.
          if (!trig_single || (trig_dir != dir)) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (cnt == CONF_LAST) begin
            cnt   <= '0;
            state <= ST_ROTATE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ROTATE: begin
          if (cnt == rot_last) begin
            cnt   <= '0;
            state <= ST_SETTLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= ST_REARM;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_REARM: begin
          // A trigger still held from the finished turn must drop first.
          if (trig_none) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.out_state        = state;
  assign bus.is_turning       = (state == ST_ROTATE) || (state == ST_SETTLE);
  assign bus.out_turn_left    = (state == ST_ROTATE) && (dir == DIR_L);
  assign bus.out_turn_right   = (state == ST_ROTATE) && (dir != DIR_L);
  assign bus.out_move_forward = bus.move_forward && ((state == ST_IDLE) || (state == ST_REARM));

endmodule

// File: tb/tb_turn_executor.sv
// tb/tb_turn_executor.sv - self-checking bench for turn_executor
module tb_turn_executor;
  localparam int C = 10;
  localparam int D = 450;
  localparam int S = 25;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  turn_executor_if bus ();

  turn_executor #(
    .CONFIRM_TIME(C),
    .TURN_90_TIME(D),
    .SETTLE_TIME (S),
    .CNT_W       (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a turn is a timeline measured from its start edge.
  int         mt;       // edge counter
  int         m_t0;     // edge the current qualification started, -1 if none
  int         m_rot;    // edge rotation started, -1 if not turning
  int         m_len;    // rotation length in cycles
  bit         m_wait;   // turn done, waiting for triggers to release
  logic [2:0] m_dir;    // {back,right,left} one-hot of the latched request

  typedef struct {
    logic [2:0] trig;
    int         hold;
    int         exp_l;
    int         exp_r;
    int         exp_busy;
    int         exp_conf;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [6:0] out_vec();
    return {bus.out_state, bus.is_turning, bus.out_turn_left, bus.out_turn_right,
            bus.out_move_forward};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_t0   = -1;
    m_rot  = -1;
    m_len  = D;
    m_wait = 1'b0;
    m_dir  = 3'b001;
  endtask

  task automatic model_edge(input logic [2:0] tv, input logic en);
    mt++;
    if (!en) begin
      m_t0   = -1;
      m_rot  = -1;
      m_wait = 1'b0;
    end else if (m_rot >= 0) begin
      if (mt - m_rot == m_len + S) begin
        m_rot  = -1;
        m_wait = 1'b1;
      end
    end else if (m_wait) begin
      if (tv == 3'b000) m_wait = 1'b0;
    end else if (m_t0 >= 0) begin
      if (tv != m_dir) m_t0 = -1;
      else if (mt - m_t0 == C) begin
        m_rot = mt;
        m_len = (m_dir == 3'b100) ? 2 * D : D;
        m_t0  = -1;
      end
    end else if (tv == 3'b001 || tv == 3'b010 || tv == 3'b100) begin
      m_t0  = mt;
      m_dir = tv;
    end
  endtask

  function automatic logic [6:0] model_expect(input logic mf);
    logic [2:0] st;
    logic       turning, l, r, fwd;
    if (m_rot >= 0)      st = (mt - m_rot < m_len) ? 3'd2 : 3'd3;
    else if (m_wait)     st = 3'd4;
    else if (m_t0 >= 0)  st = 3'd1;
    else                 st = 3'd0;
    turning = (st == 3'd2) || (st == 3'd3);
    l       = (st == 3'd2) && (m_dir == 3'b001);
    r       = (st == 3'd2) && (m_dir != 3'b001);
    fwd     = mf && ((st == 3'd0) || (st == 3'd4));
    return {st, turning, l, r, fwd};
  endfunction

  task automatic set_trig(input logic [2:0] tv);
    bus.trigger_turn_back  = tv[2];
    bus.trigger_turn_right = tv[1];
    bus.trigger_turn_left  = tv[0];
  endtask

  task automatic step();
    logic [2:0] tv;
    logic       en;
    tv = {bus.trigger_turn_back, bus.trigger_turn_right, bus.trigger_turn_left};
    en = bus.enable;
    @(posedge clk);
    model_edge(tv, en);
    #1;
    check("cycle_outputs", {25'b0, out_vec()}, {25'b0, model_expect(bus.move_forward)});
  endtask

  initial begin
    int l_cnt, r_cnt, busy_cnt, conf_cnt, rise;
    logic [2:0] prev_st;

    bus.enable       = 1'b1;
    bus.move_forward = 1'b0;
    set_trig(3'b000);
    mt = 0;
    model_reset();

    tbl[0] = '{3'b001,  100, 450,   0, 475, 1};
    tbl[1] = '{3'b100,  100,   0, 900, 925, 1};
    tbl[2] = '{3'b010,    5,   0,   0,   0, 1};
    tbl[3] = '{3'b011,  200,   0,   0,   0, 0};
    tbl[4] = '{3'b010, 1000,   0, 450, 475, 1};
    tbl[5] = '{3'b001,   10,   0,   0,   0, 1};
    tbl[6] = '{3'b001,   11, 450,   0, 475, 1};
    tbl[7] = '{3'b110,   50,   0,   0,   0, 0};
    tbl[8] = '{3'b100,   11,   0, 900, 925, 1};

    #1;
    check("reset_outputs", {25'b0, out_vec()}, 32'd0);
    #11 rst_n = 1'b1;

    // Table-driven turns: one request pattern per row, fixed observation window.
    for (int i = 0; i < 9; i++) begin
      bus.move_forward = 1'b1;
      l_cnt = 0; r_cnt = 0; busy_cnt = 0; conf_cnt = 0; rise = -1;
      prev_st = bus.out_state;
      for (int k = 0; k < 1200; k++) begin
        set_trig((k < tbl[i].hold) ? tbl[i].trig : 3'b000);
        step();
        if (bus.out_turn_left)  l_cnt++;
        if (bus.out_turn_right) r_cnt++;
        if (bus.is_turning) begin
          busy_cnt++;
          if (rise < 0) rise = k;
        end
        if (bus.out_state == 3'b001 && prev_st != 3'b001) conf_cnt++;
        prev_st = bus.out_state;
      end
      check($sformatf("row%0d_left_cycles", i),   l_cnt,    tbl[i].exp_l);
      check($sformatf("row%0d_right_cycles", i),  r_cnt,    tbl[i].exp_r);
      check($sformatf("row%0d_busy_cycles", i),   busy_cnt, tbl[i].exp_busy);
      check($sformatf("row%0d_confirms", i),      conf_cnt, tbl[i].exp_conf);
      check($sformatf("row%0d_rise_cycle", i),    rise, (tbl[i].exp_busy > 0) ? C : -1);
      check($sformatf("row%0d_final_state", i),   {29'b0, bus.out_state}, 32'd0);
    end

    // Asynchronous reset in the middle of a rotation.
    bus.move_forward = 1'b0;
    set_trig(3'b001);
    for (int k = 0; k < C + 200; k++) step();
    check("pre_reset_rotating", {31'b0, bus.out_turn_left}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_mid_turn", {25'b0, out_vec()}, 32'd0);
    model_reset();
    set_trig(3'b000);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step();

    // Enable drop in the middle of a rotation.
    set_trig(3'b010);
    for (int k = 0; k < C + 200; k++) step();
    check("pre_disable_rotating", {31'b0, bus.out_turn_right}, 32'd1);
    bus.enable = 1'b0;
    step();
    check("enable_abort_mid_turn", {25'b0, out_vec()}, 32'd0);
    set_trig(3'b000);
    step();
    bus.enable = 1'b1;
    for (int k = 0; k < 5; k++) step();

    // Randomized request patterns against the model.
    for (int seg = 0; seg < 40; seg++) begin
      logic [2:0] tv;
      int hold, gap, sel;
      tv   = ($urandom_range(0, 9) < 7) ? (3'b001 << $urandom_range(0, 2)) : 3'($urandom);
      sel  = $urandom_range(0, 9);
      hold = (sel < 5) ? $urandom_range(1, 15) :
             (sel < 8) ? $urandom_range(16, 120) : $urandom_range(100, 1000);
      gap  = $urandom_range(1, 40);
      for (int k = 0; k < hold + gap; k++) begin
        if (k < hold) set_trig(($urandom_range(0, 49) == 0) ? 3'($urandom) : tv);
        else          set_trig(3'b000);
        bus.move_forward = 1'($urandom);
        bus.enable       = ($urandom_range(0, 199) != 0);
        step();
      end
      bus.enable = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/turn_executor.md
# turn_executor

Responder side of the turn-command interface. Drive-command logic holds one of `trigger_turn_left`, `trigger_turn_right` or `trigger_turn_back` high for a trigger window, then waits for `is_turning` to fall. This block qualifies the trigger, runs a timed in-place rotation on the steering outputs and reports `is_turning` back. It sits between the command logic and the car's motion-control inputs, on the same 500 Hz tick.

## Interface
Parameters:
- `CONFIRM_TIME`, 10: cycles a single trigger must be held stable before rotation starts (20 ms).
- `TURN_90_TIME`, 450: rotation cycles for a 90° turn (0.9 s). A back turn uses 2×`TURN_90_TIME`.
- `SETTLE_TIME`, 25: cycles with steering released and `is_turning` still high after rotation.
- `CNT_W`, 16: counter width. Must hold 2×`TURN_90_TIME`.

Ports:
- `clk`  in  1  500 Hz system tick; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  block enable; low forces IDLE synchronously.
- `trigger_turn_left`  in  1  turn-left request level.
- `trigger_turn_right`  in  1  turn-right request level.
- `trigger_turn_back`  in  1  turn-around request level.
- `move_forward`  in  1  forward request from command logic.
- `is_turning`  out  1  high while a turn is executing.
- `out_turn_left`  out  1  steer-left drive.
- `out_turn_right`  out  1  steer-right drive.
- `out_move_forward`  out  1  forward drive, gated.
- `out_state`  out  3  current state encoding, for debug.

## Operation
- States and encodings: IDLE=000, CONFIRM=001, ROTATE=010, SETTLE=011, REARM=100.
- "Single trigger": exactly one of the three trigger inputs is high. "No trigger": all three are low. Any other combination is invalid.
- **IDLE**
  - Single trigger: latch the direction (`dir`: L, R or B), clear `cnt`, go to CONFIRM.
  - Invalid or no trigger: stay in IDLE.
- **CONFIRM**
  - Trigger still equal to the latched `dir`: `cnt` increments.
  - Trigger changes, goes invalid or drops: go to IDLE, with no turn issued.
  - `cnt == CONFIRM_TIME-1` with the trigger still valid: clear `cnt`, go to ROTATE.
- **ROTATE**
  - `dir` = L drives `out_turn_left`.
  - `dir` = R or B drives `out_turn_right`; a back turn rotates right.
  - Ends at `cnt == TURN_90_TIME-1` (L/R) or `cnt == 2*TURN_90_TIME-1` (B). Then clear `cnt` and go to SETTLE.
  - Trigger inputs are ignored in this state.
- **SETTLE**
  - Both steering outputs are low; `is_turning` stays high.
  - At `cnt == SETTLE_TIME-1`, go to REARM.
- **REARM**
  - `is_turning` is low.
  - Wait for no trigger, then go to IDLE. A trigger still held from the finished turn can never re-fire.
- Output decode is a pure function of the `state` and `dir` registers:
  - `is_turning` = ROTATE or SETTLE.
  - `out_move_forward` = `move_forward` AND state is IDLE or REARM. It is forced low in CONFIRM, ROTATE and SETTLE.
  - `out_turn_left` and `out_turn_right` are never high simultaneously.
- `cnt` is `CNT_W` wide and never wraps in legal operation. It is cleared on every state change.
- Parameter constraint: `CONFIRM_TIME` + `TURN_90_TIME` + `SETTLE_TIME` > 100. This guarantees `is_turning` is still high when the command side finishes its 100-cycle trigger window.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state=IDLE, `cnt`=0, `dir`=L.
  - Every output is 0 immediately; `out_state`=000.
- `enable` low on an edge: next state is IDLE and `cnt`=0. This aborts a rotation mid-turn; steering drops the same edge.
- Single trigger first sampled high at edge N:
  - CONFIRM from N.
  - ROTATE and `is_turning`=1 from edge N+`CONFIRM_TIME`.
- Left/right turn from ROTATE entry at edge R:
  - ROTATE lasts exactly `TURN_90_TIME` cycles.
  - SETTLE from R+`TURN_90_TIME`.
  - `is_turning` falls at R+`TURN_90_TIME`+`SETTLE_TIME`.
- Back turn: the ROTATE portion is 2×`TURN_90_TIME` cycles.
- A trigger glitch shorter than `CONFIRM_TIME` cycles produces no output change except `out_state` and forward gating.

## Test plan
- Left trigger held 100 cycles, then low → `is_turning` high at cycle 10; `out_turn_left` high for exactly 450 cycles; `is_turning` low at cycle 485; IDLE at cycle 486.
- Back trigger held 100 cycles → `out_turn_right` high for exactly 900 cycles; `is_turning` high for 925 cycles.
- Right trigger held 5 cycles, then low → no steering; state returns to IDLE; `is_turning` never high.
- Left and right triggers high together for 200 cycles → state stays IDLE; all outputs 0.
- Trigger held for 1000 cycles → exactly one turn; REARM until the trigger drops; no second CONFIRM.
- Reset pulse, or `enable`=0, at ROTATE cycle 200 → all outputs 0; `out_state`=000 (asynchronously for `rst_n`, next edge for `enable`).
